fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, program-counter width.
REQ-002 The block SHALL have parameter IW, default 9, machine-code width.
REQ-003 The block SHALL have parameter LUT_IDX_W, default 5, branch-target LUT index width.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1, level request to run the program from address 0.
REQ-007 The block SHALL have port stall, input, 1, freezes PC and instr for the current cycle.
REQ-008 The block SHALL have port br_take, input, 1, the currently held instruction's branch resolved taken.
REQ-009 The block SHALL have port br_rel, input, 1; 1 = relative offset, 0 = absolute target via LUT.
REQ-010 The block SHALL have port br_sel, input, LUT_IDX_W, LUT index, or signed offset when br_rel=1 (sign-extended to PC_W).
REQ-011 The block SHALL have port mach_code, input, IW, instruction-ROM data at prog_ctr, combinational.
REQ-012 The block SHALL have port prog_ctr, output, PC_W, ROM address.
REQ-013 The block SHALL have port instr, output, IW, registered instruction presented to decode.
REQ-014 The block SHALL have port instr_valid, output, 1, instr holds a live instruction.
REQ-015 The block SHALL have port done, output, 1, program halted; held until start deasserts.

Function
REQ-016 The block SHALL implement states IDLE, RUN, HALT, ACK.
REQ-017 In IDLE, start=1 SHALL set prog_ctr=0 and enter RUN next cycle; start=0 SHALL keep IDLE.
REQ-018 In RUN with stall=0, instr<=mach_code, instr_valid<=1, and prog_ctr SHALL advance by the rule below.
REQ-019 The PC rule SHALL be: br_take=0 -> +1; br_take=1,br_rel=0 -> lut[br_sel]; br_take=1,br_rel=1 -> prog_ctr+sext(br_sel); all modulo 2^PC_W (wrap 255->0 allowed, no error).
REQ-020 Branch resolution SHALL refer to the instruction held in instr, so a taken branch SHALL be followed by exactly one fall-through instruction whose instr_valid is forced 0.
REQ-021 With stall=1 in RUN, prog_ctr, instr and instr_valid SHALL hold, and br_take SHALL be ignored.
REQ-022 A latched all-zero instruction (9'b0, also the ROM out-of-range value) SHALL move RUN->HALT, with instr_valid=0 from that cycle.
REQ-023 In HALT, done SHALL be 1 and prog_ctr SHALL hold; when start=0, the block SHALL move to ACK.
REQ-024 ACK SHALL last one cycle with done=0, then the block SHALL return to IDLE; start=1 during ACK SHALL be ignored.
REQ-025 When stall and the halt condition coincide, stall SHALL win and the halt SHALL be taken after stall drops.

Reset
REQ-026 When reset=1, the block SHALL take state IDLE, prog_ctr=0, instr=0, instr_valid=0, done=0 on the next edge, in any state including mid-branch.
REQ-027 Reset SHALL take priority over start, stall and br_take.

Configuration
REQ-028 When CYCLE_COUNT_EN is defined, the block SHALL add output cyc_cnt[15:0], counting RUN cycles (stalled included), cleared on reset and on IDLE->RUN, saturating at 16'hFFFF, and frozen in HALT.
REQ-029 When CYCLE_COUNT_EN is undefined, the port and counter SHALL be absent.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the state enum, PC_W/IW/LUT_IDX_W constants and HALT_CODE=9'b0.
REQ-031 Sub-module branch_lut SHALL map LUT_IDX_W -> PC_W combinationally via a hard-coded case; the default entry SHALL be 0.

Verification
REQ-032 The bench SHALL check: reset, then start=1 -> prog_ctr sequence 0,1,2,3...; instr_valid rises one cycle after RUN entry.
REQ-033 The bench SHALL check: at instr from PC=14, br_take=1, br_rel=1, br_sel=5'b11100 (-4) -> next prog_ctr=11, one bubble with instr_valid=0.
REQ-034 The bench SHALL check: br_take=1, br_rel=0, br_sel=3, lut[3]=44 -> prog_ctr=44.
REQ-035 The bench SHALL check: stall=1 for 3 cycles at PC=20 -> prog_ctr, instr unchanged; resumes at 21.
REQ-036 The bench SHALL check: ROM returns 0 at PC=141 -> HALT, done=1; start dropped -> one ACK cycle, then IDLE.
REQ-037 The bench SHALL check: reset asserted mid-RUN at PC=60 -> all outputs zero the next cycle; with CYCLE_COUNT_EN, cyc_cnt=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer slice.
package fetch_pkg;

  localparam int PC_W      = 8;
  localparam int IW        = 9;
  localparam int LUT_IDX_W = 5;

  // An all-zero instruction word terminates the program; the ROM also returns it out of range.
  localparam logic [IW-1:0] HALT_CODE = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    ACK  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the instruction ROM and the decode/branch stage.
interface fetch_sequencer_if #(
  parameter int PC_W      = 8,
  parameter int IW        = 9,
  parameter int LUT_IDX_W = 5
);

  logic                 start;
  logic                 stall;
  logic                 br_take;
  logic                 br_rel;
  logic [LUT_IDX_W-1:0] br_sel;
  logic [IW-1:0]        mach_code;
  logic [PC_W-1:0]      prog_ctr;
  logic [IW-1:0]        instr;
  logic                 instr_valid;
  logic                 done;

  // Handshake: instr is consumed on every rising edge where instr_valid=1 and stall=0;
  // stall is the only back-pressure and freezes instr/instr_valid/prog_ctr for that cycle.
  modport master (
    output start, stall, br_take, br_rel, br_sel, mach_code,
    input  prog_ctr, instr, instr_valid, done
  );

  modport slave (
    input  start, stall, br_take, br_rel, br_sel, mach_code,
    output prog_ctr, instr, instr_valid, done
  );

endinterface

// File: rtl/branch_lut.sv
// Fixed table of absolute branch targets, indexed by br_sel; unlisted indices map to 0.
module branch_lut #(
  parameter int LUT_IDX_W = 5,
  parameter int PC_W      = 8
) (
  input  logic [LUT_IDX_W-1:0] sel,
  output logic [PC_W-1:0]      target
);

  always_comb begin
    target = '0;
    case (sel)
      LUT_IDX_W'(1): target = PC_W'(8);
      LUT_IDX_W'(2): target = PC_W'(16);
      LUT_IDX_W'(3): target = PC_W'(44);
      LUT_IDX_W'(4): target = PC_W'(60);
      LUT_IDX_W'(5): target = PC_W'(100);
      LUT_IDX_W'(6): target = PC_W'(128);
      LUT_IDX_W'(7): target = PC_W'(200);
      default:       target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program fetch sequencer: IDLE/RUN/HALT/ACK control, PC update with branches and stalls.
// Optional RUN-cycle counter output cyc_cnt is built when CYCLE_COUNT_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W      = fetch_pkg::PC_W,
  parameter int IW        = fetch_pkg::IW,
  parameter int LUT_IDX_W = fetch_pkg::LUT_IDX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  fetch_sequencer_if.slave        bus,
  output fetch_state_e            state
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0]             cyc_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            valid_q, valid_d;

  logic [PC_W-1:0] lut_target;
  logic [PC_W-1:0] rel_target;
  logic            take;
  logic            halt_hit;

  branch_lut #(
    .LUT_IDX_W (LUT_IDX_W),
    .PC_W      (PC_W)
  ) u_branch_lut (
    .sel    (bus.br_sel),
    .target (lut_target)
  );

  assign rel_target = pc_q + PC_W'(signed'(bus.br_sel));
  // Only a live held instruction can branch; the squashed slot never redirects.
  assign take       = bus.br_take & valid_q;
  assign halt_hit   = (bus.mach_code == IW'(HALT_CODE));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.start) begin
          pc_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          instr_d = bus.mach_code;
          if (take) begin
            valid_d = 1'b0;
            pc_d    = bus.br_rel ? rel_target : lut_target;
          end else if (halt_hit) begin
            valid_d = 1'b0;
            state_d = HALT;
          end else begin
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(1);
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (!bus.start) state_d = ACK;
      end
      ACK: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.done        = (state_q == HALT);
  assign state           = state_q;

`ifdef CYCLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      cnt_q <= '0;
    end else if (state_q == RUN && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cyc_cnt = cnt_q;
`endif

endmodule
